change_dispenser: RTL and testbench

Payout engine on the return side of the vending machine. On a return request it latches the amount to refund and pays it out one coin at a time to the coin hopper over a valid/ready handshake. Coins are chosen greedily, largest first, and empty or stuck hopper tubes are skipped. It sits between the return-decision logic, which supplies the amount and trigger, and the physical hopper interface.

---
 rtl/change_dispenser_if.sv | 22 ++
 rtl/change_dispenser.sv | 131 +++++++++++++
 tb/tb_change_dispenser.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Coin hopper handshake between the payout engine (master) and the hopper (slave).
// Signal names keep the engine's original port names.
interface change_dispenser_if;
  logic [2:0] i_hopper_empty;
  logic       i_coin_ready;
  logic       o_coin_valid;
  logic [2:0] o_coin_sel;

  modport master (
    input  i_hopper_empty,
    input  i_coin_ready,
    output o_coin_valid,
    output o_coin_sel
  );

  modport slave (
    output i_hopper_empty,
    output i_coin_ready,
    input  o_coin_valid,
    input  o_coin_sel
  );
endinterface

// File: rtl/change_dispenser.sv
// Refund payout engine: latches a return amount and pays it out greedily, one coin
// per hopper handshake, masking tubes that never acknowledge an offer.
module change_dispenser #(
  parameter int unsigned K_TOTAL_BITS   = 31,
  parameter int unsigned COIN_VAL0      = 100,
  parameter int unsigned COIN_VAL1      = 500,
  parameter int unsigned COIN_VAL2      = 1000,
  parameter int unsigned HOPPER_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_return_req,
  input  logic [K_TOTAL_BITS-1:0] i_return_amount,
  change_dispenser_if.master      hop,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [K_TOTAL_BITS-1:0] o_remainder,
  output logic                    o_fault
);

  localparam int unsigned CW = $clog2(HOPPER_TIMEOUT + 1);
  localparam logic [K_TOTAL_BITS-1:0] VAL0 = K_TOTAL_BITS'(COIN_VAL0);
  localparam logic [K_TOTAL_BITS-1:0] VAL1 = K_TOTAL_BITS'(COIN_VAL1);
  localparam logic [K_TOTAL_BITS-1:0] VAL2 = K_TOTAL_BITS'(COIN_VAL2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [K_TOTAL_BITS-1:0] rem_q, rem_d;
  logic [K_TOTAL_BITS-1:0] remainder_q, remainder_d;
  logic [2:0]              mask_q, mask_d;
  logic [2:0]              sel_q, sel_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    fault_q, fault_d;

  logic [2:0]              avail;
  logic [K_TOTAL_BITS-1:0] sel_val;

  always_comb begin
    avail[0] = (VAL0 <= rem_q) && !hop.i_hopper_empty[0] && !mask_q[0];
    avail[1] = (VAL1 <= rem_q) && !hop.i_hopper_empty[1] && !mask_q[1];
    avail[2] = (VAL2 <= rem_q) && !hop.i_hopper_empty[2] && !mask_q[2];
    case (sel_q)
      3'b100:  sel_val = VAL2;
      3'b010:  sel_val = VAL1;
      default: sel_val = VAL0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      remainder_q <= '0;
      mask_q      <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      remainder_q <= remainder_d;
      mask_q      <= mask_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    remainder_d = remainder_q;
    mask_d      = mask_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    case (state_q)
      S_IDLE: begin
        if (i_return_req) begin
          rem_d       = i_return_amount;
          mask_d      = '0;
          remainder_d = '0;
          fault_d     = 1'b0;
          state_d     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (avail[2])      sel_d = 3'b100;
        else if (avail[1]) sel_d = 3'b010;
        else if (avail[0]) sel_d = 3'b001;
        if (avail != '0) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end else begin
          // Captured on the way into DONE so it is already valid while o_done is high.
          remainder_d = rem_q;
          state_d     = S_DONE;
        end
      end
      S_ISSUE: begin
        if (hop.i_coin_ready) begin
          rem_d   = rem_q - sel_val;
          state_d = S_SELECT;
        end else if (cnt_q == CW'(HOPPER_TIMEOUT - 1)) begin
          // The HOPPER_TIMEOUT-th unanswered cycle retires this tube for the payout.
          mask_d  = mask_q | sel_q;
          fault_d = 1'b1;
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign hop.o_coin_valid = (state_q == S_ISSUE);
  assign hop.o_coin_sel   = (state_q == S_ISSUE) ? sel_q : 3'b000;
  assign o_busy           = (state_q != S_IDLE);
  assign o_done           = (state_q == S_DONE);
  assign o_remainder      = remainder_q;
  assign o_fault          = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: table of payouts with hand-computed coin
// sequences, plus hopper-timeout, ignored-request and mid-payout reset sequences.
module tb_change_dispenser;

  localparam int BUDGET = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        ret_req;
  logic [30:0] ret_amt;
  logic        o_busy, o_done, o_fault;
  logic [30:0] o_remainder;

  int checks = 0;
  int errors = 0;

  change_dispenser_if hop ();

  change_dispenser #(
    .K_TOTAL_BITS  (31),
    .COIN_VAL0     (100),
    .COIN_VAL1     (500),
    .COIN_VAL2     (1000),
    .HOPPER_TIMEOUT(8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_return_req   (ret_req),
    .i_return_amount(ret_amt),
    .hop            (hop),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_remainder    (o_remainder),
    .o_fault        (o_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [30:0] amount;
    logic [2:0]  empty;
    int          n;
    logic [23:0] coins;     // offered coins in order, first coin in the highest used slot
    int          done_cyc;
    logic [30:0] rem;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // Samples the current cycle first, then one cycle per clock until o_done or budget.
  task automatic monitor(input int start_cyc, input int inj_cyc,
                         output logic [23:0] coins, output int n, output int done_cyc,
                         output logic [30:0] rem, output logic fault,
                         output logic busy_at_done, output logic zero_ok);
    int cyc;
    cyc = start_cyc;
    coins = '0; n = 0; done_cyc = -1; rem = '0; fault = 1'b0;
    busy_at_done = 1'b0; zero_ok = 1'b1;
    while (cyc < start_cyc + BUDGET) begin
      if (hop.o_coin_valid) begin
        coins = {coins[20:0], hop.o_coin_sel};
        n++;
      end else if (hop.o_coin_sel != 3'b000) begin
        zero_ok = 1'b0;
      end
      if (o_done) begin
        done_cyc     = cyc;
        rem          = o_remainder;
        fault        = o_fault;
        busy_at_done = o_busy;
        break;
      end
      ret_req = (cyc == inj_cyc);
      ret_amt = (cyc == inj_cyc) ? 31'd500 : ret_amt;
      @(posedge clk); #1;
      cyc++;
    end
    ret_req = 1'b0;
    if (done_cyc < 0) chk("done_within_budget", 64'd0, 64'd1);
  endtask

  task automatic run(input vec_t v, input string tag, input int inj);
    logic [23:0] coins;
    int          n, done_cyc;
    logic [30:0] rem;
    logic        fault, busy_d, zero_ok;
    @(posedge clk); #1;
    hop.i_coin_ready   = 1'b1;
    hop.i_hopper_empty = v.empty;
    ret_req            = 1'b1;
    ret_amt            = v.amount;
    @(posedge clk); #1;
    ret_req = 1'b0;
    chk({tag, ".busy_c1"}, 64'(o_busy), 64'd1);
    monitor(1, inj, coins, n, done_cyc, rem, fault, busy_d, zero_ok);
    chk({tag, ".ncoins"}, 64'(n), 64'(v.n));
    chk({tag, ".coins"}, 64'(coins), 64'(v.coins));
    chk({tag, ".done_cyc"}, 64'(done_cyc), 64'(v.done_cyc));
    chk({tag, ".remainder"}, 64'(rem), 64'(v.rem));
    chk({tag, ".fault"}, 64'(fault), 64'd0);
    chk({tag, ".busy_done"}, 64'(busy_d), 64'd1);
    chk({tag, ".sel_zero_idle"}, 64'(zero_ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [23:0] coins;
    int          n, done_cyc, dones;
    logic [30:0] rem;
    logic        fault, busy_d, zero_ok;
    vec_t        v;

    vecs[0] = '{31'd1600, 3'b000, 3, 24'({3'b100, 3'b010, 3'b001}), 8, 31'd0};
    vecs[1] = '{31'd150,  3'b000, 1, 24'({3'b001}), 4, 31'd50};
    vecs[2] = '{31'd1000, 3'b100, 2, 24'({3'b010, 3'b010}), 6, 31'd0};
    vecs[3] = '{31'd0,    3'b000, 0, 24'd0, 2, 31'd0};
    vecs[4] = '{31'd2650, 3'b010, 8, {3'b100, 3'b100, 3'b001, 3'b001,
                                      3'b001, 3'b001, 3'b001, 3'b001}, 18, 31'd50};
    vecs[5] = '{31'd99,   3'b000, 0, 24'd0, 2, 31'd99};
    vecs[6] = '{31'd700,  3'b001, 1, 24'({3'b010}), 4, 31'd200};
    vecs[7] = '{31'd600,  3'b111, 0, 24'd0, 2, 31'd600};

    reset = 1'b1;
    ret_req = 1'b0;
    ret_amt = '0;
    hop.i_coin_ready = 1'b0;
    hop.i_hopper_empty = 3'b000;
    #3;
    chk("rst.valid", 64'(hop.o_coin_valid), 64'd0);
    chk("rst.sel", 64'(hop.o_coin_sel), 64'd0);
    chk("rst.busy", 64'(o_busy), 64'd0);
    chk("rst.done", 64'(o_done), 64'd0);
    chk("rst.remainder", 64'(o_remainder), 64'd0);
    chk("rst.fault", 64'(o_fault), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run(vecs[i], $sformatf("vec%0d", i), 0);

    // A request raised mid-payout must not be queued or disturb the coin sequence.
    run(vecs[0], "ignore_req", 3);

    // Stuck 1000 tube: offered for 8 cycles, withdrawn, then paid in 500s.
    @(posedge clk); #1;
    hop.i_coin_ready = 1'b0; hop.i_hopper_empty = 3'b000;
    ret_req = 1'b1; ret_amt = 31'd1000;
    @(posedge clk); #1;
    ret_req = 1'b0;
    chk("to.valid_c1", 64'(hop.o_coin_valid), 64'd0);
    for (int c = 2; c <= 9; c++) begin
      @(posedge clk); #1;
      chk($sformatf("to.valid_c%0d", c), 64'(hop.o_coin_valid), 64'd1);
      chk($sformatf("to.sel_c%0d", c), 64'(hop.o_coin_sel), 64'b100);
      if (c == 4) hop.i_hopper_empty = 3'b100;
    end
    @(posedge clk); #1;
    chk("to.valid_c10", 64'(hop.o_coin_valid), 64'd0);
    chk("to.fault_c10", 64'(o_fault), 64'd1);
    chk("to.busy_c10", 64'(o_busy), 64'd1);
    hop.i_coin_ready = 1'b1;
    @(posedge clk); #1;
    monitor(11, 0, coins, n, done_cyc, rem, fault, busy_d, zero_ok);
    chk("to.coins", 64'(coins), 64'({3'b010, 3'b010}));
    chk("to.ncoins", 64'(n), 64'd2);
    chk("to.done_cyc", 64'(done_cyc), 64'd15);
    chk("to.remainder", 64'(rem), 64'd0);
    chk("to.fault", 64'(fault), 64'd1);

    // Reset while a coin is on offer: outputs clear at once, no late o_done.
    @(posedge clk); #1;
    hop.i_coin_ready = 1'b0; hop.i_hopper_empty = 3'b000;
    ret_req = 1'b1; ret_amt = 31'd1600;
    @(posedge clk); #1;
    ret_req = 1'b0;
    @(posedge clk); #1;
    chk("mr.valid_before", 64'(hop.o_coin_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mr.valid", 64'(hop.o_coin_valid), 64'd0);
    chk("mr.sel", 64'(hop.o_coin_sel), 64'd0);
    chk("mr.busy", 64'(o_busy), 64'd0);
    chk("mr.done", 64'(o_done), 64'd0);
    chk("mr.fault", 64'(o_fault), 64'd0);
    chk("mr.remainder", 64'(o_remainder), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    hop.i_coin_ready = 1'b1;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (o_done || hop.o_coin_valid) dones++;
    end
    chk("mr.no_activity", 64'(dones), 64'd0);
    v = '{31'd500, 3'b000, 1, 24'({3'b010}), 4, 31'd0};
    run(v, "after_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
